sum_range_acc: RTL and testbench

Parametrised successor to the `Sum` accumulator block. It sums an integer sequence over a caller-supplied inclusive range `[lo, hi]`. The term is either linear (`i`) or, when compiled in, squared (`i*i`). Accumulation takes one term per clock, runs under a start/busy/done handshake, and reports a sticky overflow flag. It sits with the other HLS-style datapath kernels and is driven by a controller or testbench that holds operands stable across `start`.

---
 rtl/sum_pkg.sv | 16 +
 rtl/sum_term_gen.sv | 42 ++++
 rtl/sum_range_acc.sv | 121 ++++++++++++
 tb/tb_sum_range_acc.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// sum_pkg: shared types and constants for the sum_range_acc block.
//   sum_state_t  - controller state encoding (IDLE / RUN / DONE)
//   SUM_MODE_LIN - mode value selecting the linear term i
//   SUM_MODE_SQR - mode value selecting the squared term i*i
package sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sum_state_t;

  localparam logic SUM_MODE_LIN = 1'b0;
  localparam logic SUM_MODE_SQR = 1'b1;

endpackage

// File: rtl/sum_term_gen.sv
// sum_term_gen: combinational term generator for sum_range_acc.
// Optional feature macro: SUM_RANGE_SQUARE_EN (enables the i*i term).
// Ports:
//   idx      in  DATA_W  current term index
//   mode     in  1       SUM_MODE_LIN -> i, SUM_MODE_SQR -> i*i
//   term     out DATA_W  term value (low DATA_W bits)
//   term_ovf out 1       term did not fit in DATA_W bits
module sum_term_gen
  import sum_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] idx,
  input  logic              mode,
  output logic [DATA_W-1:0] term,
  output logic              term_ovf
);

`ifdef SUM_RANGE_SQUARE_EN
  // Full-width DATA_W x DATA_W product; the upper half flags overflow.
  logic [2*DATA_W-1:0] sq;

  assign sq = {{DATA_W{1'b0}}, idx} * {{DATA_W{1'b0}}, idx};

  always_comb begin
    term     = idx;
    term_ovf = 1'b0;
    if (mode == SUM_MODE_SQR) begin
      term     = sq[DATA_W-1:0];
      term_ovf = |sq[2*DATA_W-1:DATA_W];
    end
  end
`else
  // Linear-only build: mode is accepted but has no effect.
  logic unused_mode;

  assign unused_mode = mode;
  assign term        = idx;
  assign term_ovf    = 1'b0;
`endif

endmodule

// File: rtl/sum_range_acc.sv
// sum_range_acc: sums term(i) for i in the inclusive range [lo, hi], one
// term per clock, under a start/busy/done handshake.
// Optional feature macro: SUM_RANGE_SQUARE_EN (adds the i*i term for mode=1;
// without it mode is ignored and the linear sum is always produced).
// Ports:
//   sys_clk    in  1       clock, rising edge
//   sys_rst_n  in  1       synchronous active-low reset
//   start      in  1       job request, sampled only in IDLE
//   mode       in  1       0 = sum of i, 1 = sum of i*i
//   lo         in  DATA_W  first index (unsigned)
//   hi         in  DATA_W  last index (unsigned, inclusive)
//   busy       out 1       high in RUN and DONE
//   done       out 1       one-cycle completion pulse
//   return_val out DATA_W  result modulo 2^DATA_W, held until next job
//   ovf        out 1       sticky overflow of any term or partial sum
module sum_range_acc
  import sum_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] return_val,
  output logic              ovf
);

  sum_state_t        state;
  logic [DATA_W-1:0] idx;
  logic [DATA_W-1:0] acc;
  logic              ovf_int;
  logic [DATA_W-1:0] hi_q;
  logic              mode_q;

  logic [DATA_W-1:0] term;
  logic              term_ovf;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] acc_nxt;
  logic              ovf_nxt;

  sum_term_gen #(
    .DATA_W (DATA_W)
  ) u_term_gen (
    .idx      (idx),
    .mode     (mode_q),
    .term     (term),
    .term_ovf (term_ovf)
  );

  // One extra bit captures the adder carry-out for overflow detection.
  always_comb begin
    sum_ext = {1'b0, acc} + {1'b0, term};
    acc_nxt = sum_ext[DATA_W-1:0];
    ovf_nxt = ovf_int | sum_ext[DATA_W] | term_ovf;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      return_val <= '0;
      acc        <= '0;
      idx        <= '0;
      ovf_int    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (lo <= hi) begin
              idx     <= lo;
              hi_q    <= hi;
              mode_q  <= mode;
              acc     <= '0;
              ovf_int <= 1'b0;
              state   <= RUN;
            end else begin
              // Empty range completes immediately with a zero result.
              return_val <= '0;
              ovf        <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
        RUN: begin
          acc     <= acc_nxt;
          ovf_int <= ovf_nxt;
          // Equality test only, so hi = all-ones ends without idx wrapping.
          if (idx == hi_q) begin
            return_val <= acc_nxt;
            ovf        <= ovf_nxt;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + {{(DATA_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_range_acc.sv
// tb_sum_range_acc: directed testbench for sum_range_acc (DATA_W = 32).
// Follows SUM_RANGE_SQUARE_EN to pick the expected square-mode result.
module tb_sum_range_acc;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic        mode;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        busy;
  logic        done;
  logic [31:0] return_val;
  logic        ovf;

  int errors;
  int checks;
  int done_cnt;

  sum_range_acc #(
    .DATA_W (32)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .mode       (mode),
    .lo         (lo),
    .hi         (hi),
    .busy       (busy),
    .done       (done),
    .return_val (return_val),
    .ovf        (ovf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial done_cnt = 0;
  always @(posedge sys_clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launches a job from an IDLE cycle (called just after a negedge), waits
  // for done, and checks latency, result and the return to IDLE.
  // inject > 0 pulses start with other operands at that cycle of the job.
  task automatic run_job(input string tag, input logic [31:0] j_lo, input logic [31:0] j_hi,
                         input logic j_mode, input int exp_lat, input logic [31:0] exp_val,
                         input logic exp_ovf, input int inject);
    int k;
    int cnt0;
    cnt0  = done_cnt;
    lo    = j_lo;
    hi    = j_hi;
    mode  = j_mode;
    start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    k = 0;
    while (k < 300) begin
      @(negedge sys_clk);
      k++;
      start = 1'b0;
      if (done) break;
      if (inject > 0 && k == inject) begin
        lo    = 32'd100;
        hi    = 32'd200;
        mode  = 1'b1;
        start = 1'b1;
      end
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_val"}, return_val, exp_val);
    check({tag, "_ovf"}, ovf, exp_ovf);
    check({tag, "_busy_in_done"}, busy, 1'b1);
    @(negedge sys_clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_done_count"}, done_cnt - cnt0, 1);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    lo        = '0;
    hi        = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_val", return_val, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    run_job("lin", 32'd1, 32'd10, 1'b0, 11, 32'd55, 1'b0, 0);
`ifdef SUM_RANGE_SQUARE_EN
    run_job("sqr", 32'd1, 32'd10, 1'b1, 11, 32'd385, 1'b0, 0);
`else
    run_job("sqr", 32'd1, 32'd10, 1'b1, 11, 32'd55, 1'b0, 0);
`endif
    run_job("empty", 32'd5, 32'd3, 1'b0, 1, 32'd0, 1'b0, 0);
    run_job("bound", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 3, 32'hFFFF_FFFD, 1'b1, 0);

    // Reset in the middle of a long job: outputs clear and no done follows.
    begin
      int cnt0;
      cnt0  = done_cnt;
      lo    = 32'd1;
      hi    = 32'd100;
      mode  = 1'b0;
      start = 1'b1;
      @(posedge sys_clk);
      #1 start = 1'b0;
      repeat (20) @(negedge sys_clk);
      check("midrun_busy", busy, 1'b1);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_ovf", ovf, 1'b0);
      check("midrst_val", return_val, 32'd0);
      repeat (120) @(negedge sys_clk);
      check("midrst_no_done", done_cnt - cnt0, 0);
      check("midrst_idle", busy, 1'b0);
    end

    run_job("after_rst", 32'd1, 32'd4, 1'b0, 5, 32'd10, 1'b0, 0);
    run_job("busy_start", 32'd1, 32'd10, 1'b0, 11, 32'd55, 1'b0, 3);
    begin
      int cnt0;
      cnt0 = done_cnt;
      repeat (30) @(negedge sys_clk);
      check("busy_start_no_extra", done_cnt - cnt0, 0);
    end
    run_job("empty2", 32'd7, 32'd6, 1'b1, 1, 32'd0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
